// File: rtl/mem_sequencer.sv
// Initiator side of the 4K x 12 synchronous RAM port: turns one CPU request
// (direct, indirect or autoindex) into the RAM oe/we cycle sequence.
module mem_sequencer #(
    parameter int AW = 12,
    parameter int DW = 12,
    parameter logic [AW-1:0] AUTO_LO = 12'o0010,
    parameter logic [AW-1:0] AUTO_HI = 12'o0017
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req,
    input  logic          wr,
    input  logic          ind,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] rdata,
    output logic [AW-1:0] ea,
    output logic          ram_oe,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_IRD1 = 3'd1,
        S_IRD2 = 3'd2,
        S_IWB  = 3'd3,
        S_DRD1 = 3'd4,
        S_DRD2 = 3'd5,
        S_DWR  = 3'd6,
        S_DONE = 3'd7
    } state_t;

    localparam logic [AW-1:0] ONE_A = {{(AW-1){1'b0}}, 1'b1};

    state_t        state_q, state_d;
    logic          wr_q, wr_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [AW-1:0] ea_q, ea_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          ram_oe_q, ram_oe_d;
    logic          ram_we_q, ram_we_d;
    logic [AW-1:0] ram_addr_q, ram_addr_d;
    logic [DW-1:0] ram_wdata_q, ram_wdata_d;
    logic          auto_s;

    // Sequencing: request capture, pointer fetch/increment and data capture.
    always_comb begin
        state_d = state_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        ea_d    = ea_q;
        rdata_d = rdata_q;
        auto_s  = (addr_q >= AUTO_LO) && (addr_q <= AUTO_HI);
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    wr_d    = wr;
                    addr_d  = addr;
                    wdata_d = wdata;
                    ea_d    = addr;
                    if (ind) begin
                        state_d = S_IRD1;
                    end else begin
                        state_d = wr ? S_DWR : S_DRD1;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_IRD1: state_d = S_IRD2;
            S_IRD2: begin
                // ea doubles as the pointer register once the indirection resolves.
                if (auto_s) begin
                    ea_d    = AW'(ram_rdata) + ONE_A;
                    state_d = S_IWB;
                end else begin
                    ea_d    = AW'(ram_rdata);
                    state_d = wr_q ? S_DWR : S_DRD1;
                end
            end
            S_IWB:  state_d = wr_q ? S_DWR : S_DRD1;
            S_DRD1: state_d = S_DRD2;
            S_DRD2: begin
                rdata_d = ram_rdata;
                state_d = S_DONE;
            end
            S_DWR:  state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // RAM strobes follow the upcoming state so each pin cycle lines up with its state.
    always_comb begin
        busy_d      = (state_d != S_IDLE);
        done_d      = (state_q == S_DONE);
        ram_oe_d    = 1'b0;
        ram_we_d    = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        case (state_d)
            S_IRD1, S_IRD2: begin
                ram_oe_d   = 1'b1;
                ram_addr_d = addr_d;
            end
            S_IWB: begin
                ram_we_d    = 1'b1;
                ram_addr_d  = addr_d;
                ram_wdata_d = DW'(ea_d);
            end
            S_DRD1, S_DRD2: begin
                ram_oe_d   = 1'b1;
                ram_addr_d = ea_d;
            end
            S_DWR: begin
                ram_we_d    = 1'b1;
                ram_addr_d  = ea_d;
                ram_wdata_d = wdata_d;
            end
            default: begin
                ram_oe_d = 1'b0;
                ram_we_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any sequence in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            ea_q        <= '0;
            rdata_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ram_oe_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            ea_q        <= ea_d;
            rdata_q     <= rdata_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            ram_oe_q    <= ram_oe_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign rdata     = rdata_q;
    assign ea        = ea_q;
    assign ram_oe    = ram_oe_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;

endmodule

// File: doc/mem_sequencer.md
Name: mem_sequencer

Overview:
- Initiator side of the 4K x 12 synchronous RAM interface: turns one CPU memory request into the RAM oe/we cycle sequence.
- Handles PDP-8 indirect addressing and autoindex (pointer locations 0010-0017 octal): fetch pointer, optional increment and write-back, then data access.
- Sits between the CPU major-state logic and the RAM. One request is in flight at a time; completion is signalled by a one-cycle done pulse.

Parameters:
- AW, 12, address width (RAM depth = 2^AW words).
- DW, 12, data word width.
- AUTO_LO, 12'o0010, first autoindex location.
- AUTO_HI, 12'o0017, last autoindex location.

Ports:
- clk  in  1  system clock; all state on posedge.
- reset  in  1  asynchronous, active-high reset.
- req  in  1  CPU request strobe; sampled only when busy=0.
- wr  in  1  1=write, 0=read; sampled with req.
- ind  in  1  1=addr is the address of a pointer (indirect access); sampled with req.
- addr  in  AW  direct address, or pointer address when ind=1.
- wdata  in  DW  write data; sampled with req.
- busy  out  1  high from the cycle after acceptance until done.
- done  out  1  one-cycle completion pulse.
- rdata  out  DW  read result; valid while done=1, then held until the next read completes.
- ea  out  AW  effective address used for the data access; valid with done.
- ram_oe  out  1  RAM output enable / read strobe.
- ram_we  out  1  RAM write enable.
- ram_addr  out  AW  RAM address.
- ram_wdata  out  DW  data to RAM write port.
- ram_rdata  in  DW  data from RAM read port. The RAM registers its read and drives Z when oe=0.

Behaviour:
- RAM read protocol:
  - Hold ram_oe=1 with a stable ram_addr for two cycles (RD1, RD2).
  - Sample ram_rdata at the end of RD2. Data is never sampled while ram_oe=0.
- RAM write protocol: ram_we=1 for exactly one cycle, with ram_addr and ram_wdata valid in that cycle.
- Invariant: ram_oe and ram_we are never both 1.
- States: IDLE, IRD1, IRD2, IWB, DRD1, DRD2, DWR, DONE.
- Transitions:
  - IDLE: req=1 latches wr, ind, addr and wdata.
    - ind=1 goes to IRD1.
    - ind=0 with wr=0 goes to DRD1; ind=0 with wr=1 goes to DWR.
  - IRD1 goes to IRD2.
  - IRD2 latches ptr = ram_rdata.
    - If AUTO_LO <= addr <= AUTO_HI: ptr = ram_rdata + 1, modulo 2^AW (7777 wraps to 0000), and the next state is IWB.
    - Otherwise the next state is DRD1 (wr=0) or DWR (wr=1).
  - IWB: ram_we=1, ram_addr=addr, ram_wdata=ptr; next state DRD1 or DWR.
  - DRD1 goes to DRD2. DRD2 latches rdata = ram_rdata and goes to DONE.
  - DWR: ram_we=1, ram_addr=ea, ram_wdata=latched wdata; goes to DONE.
  - DONE: done=1 for one cycle, then IDLE. req is ignored in DONE; it is accepted from IDLE in the following cycle.
- ea equals the latched addr for a direct access and ptr for an indirect access. ind=0 never autoincrements, even for addresses in 0010-0017.
- Latency, counted from the accepting edge k (done high in the cycle beginning at edge k+n):
  - direct read, n=3;
  - direct write, n=2;
  - indirect read, n=5 (autoindex read, n=6);
  - indirect write, n=4 (autoindex write, n=5).
- An indirect write whose pointer addresses itself (ptr == addr after increment) is legal; accesses are performed strictly in sequence.
- busy=1 in every state except IDLE. req while busy=1 is ignored and not queued.
- In IDLE, ram_oe=0 and ram_we=0; ram_addr and ram_wdata are don't-care but must be held stable (no glitching).
- Reset (asynchronous, any state, including mid-sequence):
  - state goes to IDLE;
  - busy, done, ram_oe and ram_we go to 0;
  - rdata, ea, ram_addr and ram_wdata go to 0.
  - A pending pointer write-back is abandoned, and RAM contents are not altered after reset asserts.

Test Plan:
- Preload mem[0200]=1234 and issue a direct read of 0200 -> ram_oe high for 2 cycles at address 0200; done at k+3; rdata=1234, ea=0200; ram_we never high.
- Direct write of 5555 to 0300, then a direct read of 0300 -> one ram_we cycle at 0300 with data 5555; done at k+2; the read returns 5555.
- Preload mem[0050]=0400 and mem[0400]=7070; indirect read via 0050 -> ea=0400, rdata=7070, done at k+5; no write occurs; mem[0050] is unchanged.
- Preload mem[0010]=7777 and mem[0000]=4321; autoindex read via 0010 -> write-back of 0000 to 0010; ea=0000, rdata=4321, done at k+6; mem[0010]=0000 afterwards (wrap-around).
- Preload mem[0017]=0500; autoindex write of 1111 via 0017 -> mem[0017]=0501 and mem[0501]=1111; done at k+5. Also issue a direct write to 0010 with ind=0 -> no increment occurs.
- Assert reset during IWB of an autoindex access; also pulse req while busy -> ram_we drops immediately, state returns to IDLE, no done pulse, pointer location unchanged; the req asserted while busy is not serviced afterwards.
